uart_cfg_sequencer: RTL and testbench
=====================================

Name: uart_cfg_sequencer

Overview:
Bus-master controller that programs the UART register block after reset or on software request. It drives the register block's wr/rd/addr/din port and reads its dout. Programming order is LCR with DLAB=1, DLL, DLM, LCR with DLAB=0, FCR, then a scratch-pad write/read-back self-test. It then polls LSR until the transmitter is idle, and reports done or an error code. It sits between the SoC boot/config logic and the UART register block.

Parameters:
SCR_PATTERN, 8'hA5, byte written to and read back from the scratch pad.
RD_LAT, 2, cycles from the rd pulse until reg_rdata is valid. Matches the register block's two-stage read (temp register, then registered dout).
POLL_MAX, 255, maximum number of LSR reads before a timeout error; range 1..255.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to run the sequence; ignored while busy
cfg_div  in  16  baud divisor; [7:0] goes to DLL, [15:8] to DLM
cfg_lcr  in  8  line format; bit 7 (DLAB) is ignored and forced by the sequencer
cfg_rx_trig  in  2  RX trigger select written to FCR[7:6]
reg_wr  out  1  write strobe to the register block
reg_rd  out  1  read strobe to the register block
reg_addr  out  3  register address
reg_wdata  out  8  write data
reg_rdata  in  8  register block dout
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at sequence end, on success or error
error  out  1  sticky; cleared when the next start is accepted
err_code  out  2  00 none, 01 scratch mismatch, 10 LSR poll timeout; sticky with error

Behaviour:
- Reset: state IDLE; reg_wr, reg_rd, reg_addr, reg_wdata, busy, done, error, err_code all 0; poll counter 0. Reset asserted mid-sequence aborts immediately. No further strobes are issued and no done pulse is produced.
- Input latching: cfg_div, cfg_lcr and cfg_rx_trig are captured on the edge where start is accepted. Later changes have no effect on a running sequence.
- Writes: exactly one cycle with reg_wr=1 and addr/data stable; consecutive write states are back to back. reg_wr and reg_rd are never high together.
- Write states, one cycle each, in order:
  - W_LCR1: addr 3, data {1, cfg_lcr[6:0]}
  - W_DLL: addr 0, data cfg_div[7:0]
  - W_DLM: addr 1, data cfg_div[15:8]
  - W_LCR0: addr 3, data {0, cfg_lcr[6:0]}
  - W_FCR: addr 2, data {cfg_rx_trig, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1}. DMA is off; both FIFOs are reset and enabled.
  - W_SCR: addr 7, data SCR_PATTERN
- Address 0 is never written while DLAB=0, so the sequencer never pushes the TX FIFO.
- Reads: one cycle with reg_rd=1, then RD_LAT cycles with reg_rd=0 and reg_addr held. reg_rdata is sampled on the edge ending the last wait cycle.
- R_SCR: read addr 7. If data ≠ SCR_PATTERN, go to ERR with code 01. Otherwise go to R_LSR.
- R_LSR: read addr 5.
  - If bit 6 (TEMT) and bit 5 (THRE) are both 1, go to DONE.
  - Else increment the poll counter; if it equals POLL_MAX, go to ERR with code 10; else re-read immediately.
- DONE / ERR: one cycle. done=1 and busy=0 in that cycle. ERR also sets error and err_code. Then return to IDLE.
- Nominal latency: start high in cycle 0; writes in cycles 1–6; SCR read cycles 7–9; LSR read cycles 10–12; done=1 in cycle 13.
- start while busy, or in the DONE/ERR cycle, is ignored.
- Idle outputs: in IDLE and in read-wait cycles, reg_wdata=0. reg_addr=0 in IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - address constants ADDR_RBR_THR=0, ADDR_DLM_IER=1, ADDR_FCR=2, ADDR_LCR=3, ADDR_LSR=5, ADDR_SCR=7
  - LSR bit indices LSR_TEMT=6, LSR_THRE=5
  - the existing lcr_t/fcr_t/lsr_t structs
  - enum seq_state_t
  - enum seq_err_t
- Single module; no sub-module needed.

Test Plan:
- Reset, then start with cfg_div=16'h0145, cfg_lcr=8'h03, trig=2'b10, against the real register block → write trace (addr,data): (3,83), (0,45), (1,01), (3,03), (2,87), (7,A5). done in cycle 13; error=0; register block divisor = 0145 and lcr = 03.
- Register-block model returning 8'h5A for the SCR read → done pulses, error=1, err_code=01, no LSR read issued.
- LSR model returns 8'h00 three times, then 8'h60 → exactly 4 LSR reads, done with error=0, done in cycle 22.
- LSR stuck at 8'h00, POLL_MAX=4 → exactly 4 reads, then error=1, err_code=10.
- Assert rst during W_DLM → next cycle all outputs 0, no done. A fresh start reruns the full 6-write trace from W_LCR1.
- start pulsed again in cycle 5 of a run, and cfg_div changed mid-run → ignored; trace uses the originally latched values; single done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Register map, register layouts and sequencer types shared by
//               the UART register block and its configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [2:0] ADDR_RBR_THR = 3'd0;
    localparam logic [2:0] ADDR_DLM_IER = 3'd1;
    localparam logic [2:0] ADDR_FCR     = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_LSR     = 3'd5;
    localparam logic [2:0] ADDR_SCR     = 3'd7;

    localparam int LSR_TEMT = 6;
    localparam int LSR_THRE = 5;

    typedef struct packed {
        logic       dlab;
        logic       brk;
        logic       stick_par;
        logic       even_par;
        logic       par_en;
        logic       stop_bits;
        logic [1:0] word_len;
    } lcr_t;

    typedef struct packed {
        logic [1:0] rx_trig;
        logic [1:0] rsvd;
        logic       dma_mode;
        logic       tx_rst;
        logic       rx_rst;
        logic       fifo_en;
    } fcr_t;

    typedef struct packed {
        logic rx_fifo_err;
        logic temt;
        logic thre;
        logic brk_int;
        logic frame_err;
        logic par_err;
        logic overrun;
        logic data_rdy;
    } lsr_t;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_W_LCR1     = 4'd1,
        S_W_DLL      = 4'd2,
        S_W_DLM      = 4'd3,
        S_W_LCR0     = 4'd4,
        S_W_FCR      = 4'd5,
        S_W_SCR      = 4'd6,
        S_R_SCR      = 4'd7,
        S_R_SCR_WAIT = 4'd8,
        S_R_LSR      = 4'd9,
        S_R_LSR_WAIT = 4'd10,
        S_DONE       = 4'd11,
        S_ERR        = 4'd12
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'b00,
        ERR_SCR_MISMATCH = 2'b01,
        ERR_POLL_TIMEOUT = 2'b10
    } seq_err_t;

endpackage
`default_nettype wire

// File: rtl/uart_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_sequencer
// Description : Bus master that programs divisor, line format and FIFOs of the
//               UART register block, self-tests the scratch pad, then waits
//               for the transmitter to go idle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_sequencer
    import uart_pkg::*;
#(
    parameter logic [7:0] SCR_PATTERN = 8'hA5,
    parameter int         RD_LAT      = 2,     // must be >= 1
    parameter int         POLL_MAX    = 255    // 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_cfg_div,
    input  logic [7:0]  i_cfg_lcr,
    input  logic [1:0]  i_cfg_rx_trig,
    output logic        o_reg_wr,
    output logic        o_reg_rd,
    output logic [2:0]  o_reg_addr,
    output logic [7:0]  o_reg_wdata,
    input  logic [7:0]  i_reg_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_err_code
);

    localparam logic [7:0] c_LAST_WAIT = 8'(RD_LAT - 1);
    localparam logic [7:0] c_POLL_MAX  = 8'(POLL_MAX);

    seq_state_t r_state;
    seq_state_t w_next;

    logic [15:0] r_div;
    logic [6:0]  r_lcr;
    logic [1:0]  r_trig;
    logic [7:0]  r_wait;
    logic [7:0]  r_poll;
    logic        r_error;
    seq_err_t    r_err_code;

    logic        w_accept;
    logic        w_in_wait;
    logic        w_last_wait;
    logic        w_lsr_idle;
    logic [7:0]  w_poll_inc;
    seq_err_t    w_err_val;
    lcr_t        w_lcr_dlab1;
    lcr_t        w_lcr_dlab0;
    fcr_t        w_fcr;

    assign w_accept    = (r_state == S_IDLE) && i_start;
    assign w_in_wait   = (r_state == S_R_SCR_WAIT) || (r_state == S_R_LSR_WAIT);
    assign w_last_wait = w_in_wait && (r_wait == c_LAST_WAIT);
    assign w_lsr_idle  = i_reg_rdata[LSR_TEMT] && i_reg_rdata[LSR_THRE];
    assign w_poll_inc  = r_poll + 8'd1;

    assign w_lcr_dlab1 = lcr_t'({1'b1, r_lcr});
    assign w_lcr_dlab0 = lcr_t'({1'b0, r_lcr});
    // DMA off; both FIFOs flushed and enabled in the same write.
    assign w_fcr = '{rx_trig: r_trig, rsvd: 2'b00, dma_mode: 1'b0,
                     tx_rst: 1'b1, rx_rst: 1'b1, fifo_en: 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= 16'h0000;
            r_lcr      <= 7'h00;
            r_trig     <= 2'b00;
            r_wait     <= 8'h00;
            r_poll     <= 8'h00;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_div      <= i_cfg_div;
                r_lcr      <= i_cfg_lcr[6:0];
                r_trig     <= i_cfg_rx_trig;
                r_poll     <= 8'h00;
                r_error    <= 1'b0;
                r_err_code <= ERR_NONE;
            end

            if (w_in_wait && !w_last_wait) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'h00;
            end

            if ((r_state == S_R_LSR_WAIT) && w_last_wait && !w_lsr_idle) begin
                r_poll <= w_poll_inc;
            end

            if (w_next == S_ERR) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_val;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_err_val   = ERR_NONE;
        o_reg_wr    = 1'b0;
        o_reg_rd    = 1'b0;
        o_reg_addr  = ADDR_RBR_THR;
        o_reg_wdata = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_W_LCR1;
                end
            end
            S_W_LCR1: begin
                o_reg_wr    = 1'b1;
                o_reg_addr  = ADDR_LCR;
                o_reg_wdata = w_lcr_dlab1;
                w_next      = S_W_DLL;
            end
            S_W_DLL: begin
                o_reg_wr    = 1'b1;
                o_reg_addr  = ADDR_RBR_THR;
                o_reg_wdata = r_div[7:0];
                w_next      = S_W_DLM;
            end
            S_W_DLM: begin
                o_reg_wr    = 1'b1;
                o_reg_addr  = ADDR_DLM_IER;
                o_reg_wdata = r_div[15:8];
                w_next      = S_W_LCR0;
            end
            S_W_LCR0: begin
                o_reg_wr    = 1'b1;
                o_reg_addr  = ADDR_LCR;
                o_reg_wdata = w_lcr_dlab0;
                w_next      = S_W_FCR;
            end
            S_W_FCR: begin
                o_reg_wr    = 1'b1;
                o_reg_addr  = ADDR_FCR;
                o_reg_wdata = w_fcr;
                w_next      = S_W_SCR;
            end
            S_W_SCR: begin
                o_reg_wr    = 1'b1;
                o_reg_addr  = ADDR_SCR;
                o_reg_wdata = SCR_PATTERN;
                w_next      = S_R_SCR;
            end
            S_R_SCR: begin
                o_reg_rd   = 1'b1;
                o_reg_addr = ADDR_SCR;
                w_next     = S_R_SCR_WAIT;
            end
            S_R_SCR_WAIT: begin
                o_reg_addr = ADDR_SCR;
                if (w_last_wait) begin
                    if (i_reg_rdata != SCR_PATTERN) begin
                        w_next    = S_ERR;
                        w_err_val = ERR_SCR_MISMATCH;
                    end else begin
                        w_next = S_R_LSR;
                    end
                end
            end
            S_R_LSR: begin
                o_reg_rd   = 1'b1;
                o_reg_addr = ADDR_LSR;
                w_next     = S_R_LSR_WAIT;
            end
            S_R_LSR_WAIT: begin
                o_reg_addr = ADDR_LSR;
                if (w_last_wait) begin
                    if (w_lsr_idle) begin
                        w_next = S_DONE;
                    end else if (w_poll_inc == c_POLL_MAX) begin
                        w_next    = S_ERR;
                        w_err_val = ERR_POLL_TIMEOUT;
                    end else begin
                        w_next = S_R_LSR;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign o_done     = (r_state == S_DONE) || (r_state == S_ERR);
    assign o_error    = r_error;
    assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cfg_sequencer
// Description : Directed self-checking bench for uart_cfg_sequencer with a
//               behavioural register block (two-stage read) on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i2_start = 1'b0;
    logic [15:0] i_cfg_div = 16'h0000;
    logic [7:0]  i_cfg_lcr = 8'h00;
    logic [1:0]  i_cfg_rx_trig = 2'b00;

    logic        o_reg_wr, o_reg_rd, o_busy, o_done, o_error;
    logic [2:0]  o_reg_addr;
    logic [7:0]  o_reg_wdata, m_dout;
    logic [1:0]  o_err_code;

    logic        o2_reg_wr, o2_reg_rd, o2_busy, o2_done, o2_error;
    logic [2:0]  o2_reg_addr;
    logic [7:0]  o2_reg_wdata, m2_dout;
    logic [1:0]  o2_err_code;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cfg_sequencer #(.SCR_PATTERN(8'hA5), .RD_LAT(2), .POLL_MAX(255)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_div(i_cfg_div),
        .i_cfg_lcr(i_cfg_lcr), .i_cfg_rx_trig(i_cfg_rx_trig),
        .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd), .o_reg_addr(o_reg_addr),
        .o_reg_wdata(o_reg_wdata), .i_reg_rdata(m_dout), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code)
    );

    uart_cfg_sequencer #(.SCR_PATTERN(8'hA5), .RD_LAT(2), .POLL_MAX(4)) dut2 (
        .clk(clk), .rst(rst), .i_start(i2_start), .i_cfg_div(i_cfg_div),
        .i_cfg_lcr(i_cfg_lcr), .i_cfg_rx_trig(i_cfg_rx_trig),
        .o_reg_wr(o2_reg_wr), .o_reg_rd(o2_reg_rd), .o_reg_addr(o2_reg_addr),
        .o_reg_wdata(o2_reg_wdata), .i_reg_rdata(m2_dout), .o_busy(o2_busy),
        .o_done(o2_done), .o_error(o2_error), .o_err_code(o2_err_code)
    );

    // Register block model for dut: divisor/LCR/SCR storage, LSR stimulus,
    // read data through a temp register then a registered dout.
    logic [7:0] m_lcr = 8'h00, m_dll = 8'h00, m_dlm = 8'h00, m_scr = 8'h00;
    logic [7:0] m_tmp = 8'h00;
    int         m_tx_push = 0;
    int         m_lsr_rd = 0;
    logic       scr_force = 1'b0;
    int         lsr_base = 0;
    int         lsr_zero_n = 0;

    initial m_dout = 8'h00;
    always @(posedge clk) begin
        if (o_reg_wr) begin
            case (o_reg_addr)
                3'd0: if (m_lcr[7]) m_dll <= o_reg_wdata; else m_tx_push <= m_tx_push + 1;
                3'd1: if (m_lcr[7]) m_dlm <= o_reg_wdata;
                3'd3: m_lcr <= o_reg_wdata;
                3'd7: m_scr <= o_reg_wdata;
                default: ;
            endcase
        end
        if (o_reg_rd) begin
            case (o_reg_addr)
                3'd7: m_tmp <= scr_force ? 8'h5A : m_scr;
                3'd5: begin
                    m_tmp    <= ((m_lsr_rd - lsr_base) < lsr_zero_n) ? 8'h00 : 8'h60;
                    m_lsr_rd <= m_lsr_rd + 1;
                end
                default: m_tmp <= 8'h00;
            endcase
        end
        m_dout <= m_tmp;
    end

    // dut2 sees a healthy scratch pad but an LSR stuck at zero.
    logic [7:0] m2_tmp = 8'h00;
    initial m2_dout = 8'h00;
    always @(posedge clk) begin
        if (o2_reg_rd) m2_tmp <= (o2_reg_addr == 3'd7) ? 8'hA5 : 8'h00;
        m2_dout <= m2_tmp;
    end

    // Bus monitors, sampled mid-cycle.
    logic [10:0] wr_q[$];
    int done_cnt = 0, done_cyc = 0, lsr_cnt = 0, both_cnt = 0;
    int done2_cnt = 0, done2_cyc = 0, lsr2_cnt = 0;
    always @(negedge clk) begin
        if (o_reg_wr) wr_q.push_back({o_reg_addr, o_reg_wdata});
        if (o_reg_wr && o_reg_rd) both_cnt <= both_cnt + 1;
        if (o_reg_rd && o_reg_addr == 3'd5) lsr_cnt <= lsr_cnt + 1;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (o2_reg_rd && o2_reg_addr == 3'd5) lsr2_cnt <= lsr2_cnt + 1;
        if (o2_done) begin
            done2_cnt <= done2_cnt + 1;
            done2_cyc <= cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] div, input logic [7:0] lcr,
                               input logic [1:0] trig, output int t0);
        tick();
        i_start       = 1'b1;
        i_cfg_div     = div;
        i_cfg_lcr     = lcr;
        i_cfg_rx_trig = trig;
        t0            = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int dbase, output bit timed_out);
        int n = 0;
        while (done_cnt == dbase && n < 200) begin
            tick();
            n++;
        end
        timed_out = (done_cnt == dbase);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata} !== 13'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", {o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata});
        end
        checks++;
        if ({o_busy, o_done, o_error, o_err_code} !== 5'h0) begin
            errors++;
            $display("FAIL reset_status: got %b expected 00000", {o_busy, o_done, o_error, o_err_code});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        logic [10:0] exp [6];
        int base, dbase, t0;
        bit to;
        exp = '{{3'd3, 8'h83}, {3'd0, 8'h45}, {3'd1, 8'h01},
                {3'd3, 8'h03}, {3'd2, 8'h87}, {3'd7, 8'hA5}};
        base = wr_q.size();
        dbase = done_cnt;
        pulse_start(16'h0145, 8'h03, 2'b10, t0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy: got %b expected 1", o_busy);
        end
        wait_done(dbase, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL nominal_timeout: got no done expected done");
        end
        checks++;
        if (done_cyc - t0 != 13) begin
            errors++;
            $display("FAIL nominal_latency: got %0d expected 13", done_cyc - t0);
        end
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_err_busy: got err=%b busy=%b expected 0 0", o_error, o_busy);
        end
        checks++;
        if (wr_q.size() - base != 6) begin
            errors++;
            $display("FAIL nominal_wr_count: got %0d expected 6", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wr_q[base + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL nominal_wr%0d: got %h expected %h", i, wr_q[base + i], exp[i]);
                end
            end
        end
        checks++;
        if ({m_dlm, m_dll} !== 16'h0145 || m_lcr !== 8'h03) begin
            errors++;
            $display("FAIL nominal_regs: got div=%h lcr=%h expected 0145 03", {m_dlm, m_dll}, m_lcr);
        end
    endtask

    task automatic test_scr_mismatch();
        int dbase, lbase, t0;
        bit to;
        scr_force = 1'b1;
        dbase = done_cnt;
        lbase = lsr_cnt;
        pulse_start(16'h0145, 8'h03, 2'b10, t0);
        wait_done(dbase, to);
        checks++;
        if (to || done_cyc - t0 != 10) begin
            errors++;
            $display("FAIL scr_done_cycle: got %0d expected 10", done_cyc - t0);
        end
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 2'b01) begin
            errors++;
            $display("FAIL scr_err: got err=%b code=%b expected 1 01", o_error, o_err_code);
        end
        repeat (3) tick();
        checks++;
        if (lsr_cnt != lbase || o_error !== 1'b1) begin
            errors++;
            $display("FAIL scr_no_lsr: got lsr_reads=%0d err=%b expected 0 1", lsr_cnt - lbase, o_error);
        end
        scr_force = 1'b0;
    endtask

    task automatic test_lsr_poll();
        int dbase, lbase, t0;
        bit to;
        lsr_base = m_lsr_rd;
        lsr_zero_n = 3;
        dbase = done_cnt;
        lbase = lsr_cnt;
        pulse_start(16'h0145, 8'h03, 2'b10, t0);
        tick();
        checks++;
        if (o_error !== 1'b0 || o_err_code !== 2'b00) begin
            errors++;
            $display("FAIL poll_err_cleared: got err=%b code=%b expected 0 00", o_error, o_err_code);
        end
        wait_done(dbase, to);
        checks++;
        if (to || done_cyc - t0 != 22) begin
            errors++;
            $display("FAIL poll_done_cycle: got %0d expected 22", done_cyc - t0);
        end
        checks++;
        if (lsr_cnt - lbase != 4 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL poll_reads: got reads=%0d err=%b expected 4 0", lsr_cnt - lbase, o_error);
        end
        lsr_zero_n = 0;
    endtask

    task automatic test_timeout();
        int dbase, lbase, t0, n;
        dbase = done2_cnt;
        lbase = lsr2_cnt;
        tick();
        i2_start = 1'b1;
        t0 = cyc;
        tick();
        i2_start = 1'b0;
        n = 0;
        while (done2_cnt == dbase && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done2_cnt == dbase || done2_cyc - t0 != 22) begin
            errors++;
            $display("FAIL timeout_done_cycle: got %0d expected 22", done2_cyc - t0);
        end
        checks++;
        if (lsr2_cnt - lbase != 4) begin
            errors++;
            $display("FAIL timeout_reads: got %0d expected 4", lsr2_cnt - lbase);
        end
        checks++;
        if (o2_error !== 1'b1 || o2_err_code !== 2'b10) begin
            errors++;
            $display("FAIL timeout_err: got err=%b code=%b expected 1 10", o2_error, o2_err_code);
        end
    endtask

    task automatic test_reset_mid();
        int base, dbase, t0, n;
        base = wr_q.size();
        dbase = done_cnt;
        pulse_start(16'h0145, 8'h03, 2'b10, t0);
        n = 0;
        while (cyc < t0 + 3 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (o_reg_wr !== 1'b1 || o_reg_addr !== 3'd1) begin
            errors++;
            $display("FAIL mid_at_dlm: got wr=%b addr=%0d expected 1 1", o_reg_wr, o_reg_addr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata, o_busy, o_done, o_error, o_err_code} !== 18'h0) begin
            errors++;
            $display("FAIL mid_outputs: got %h expected 0",
                     {o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata, o_busy, o_done, o_error, o_err_code});
        end
        rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (wr_q.size() - base != 3 || done_cnt != dbase) begin
            errors++;
            $display("FAIL mid_abort: got writes=%0d dones=%0d expected 3 0", wr_q.size() - base, done_cnt - dbase);
        end
        test_nominal();
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp [6];
        int base, dbase, t0, n;
        exp = '{{3'd3, 8'h9B}, {3'd0, 8'h34}, {3'd1, 8'h12},
                {3'd3, 8'h1B}, {3'd2, 8'hC7}, {3'd7, 8'hA5}};
        base = wr_q.size();
        dbase = done_cnt;
        pulse_start(16'h1234, 8'h9B, 2'b11, t0);
        n = 0;
        while (cyc < t0 + 5 && n < 20) begin
            tick();
            n++;
        end
        i_start = 1'b1;
        i_cfg_div = 16'hBEEF;
        i_cfg_lcr = 8'h1F;
        i_cfg_rx_trig = 2'b01;
        tick();
        i_start = 1'b0;
        repeat (30) tick();
        checks++;
        if (done_cnt - dbase != 1 || done_cyc - t0 != 13) begin
            errors++;
            $display("FAIL b2b_done: got dones=%0d cycle=%0d expected 1 13", done_cnt - dbase, done_cyc - t0);
        end
        checks++;
        if (wr_q.size() - base != 6) begin
            errors++;
            $display("FAIL b2b_wr_count: got %0d expected 6", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wr_q[base + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_wr%0d: got %h expected %h", i, wr_q[base + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (both_cnt != 0 || m_tx_push != 0) begin
            errors++;
            $display("FAIL bus_rules: got wr_rd_overlap=%0d tx_push=%0d expected 0 0", both_cnt, m_tx_push);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_scr_mismatch();
        test_lsr_poll();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_bus_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
